// File: rtl/vip_frame_stream_gen.sv
// Pixel-stream source: emits vsync/href/clken plus an 8-bit Y test pattern
// with programmable active size, blanking and pixel rate.
module vip_frame_stream_gen #(
  parameter int unsigned IMG_HDISP     = 640,
  parameter int unsigned IMG_VDISP     = 480,
  parameter int unsigned H_BLANK       = 160,
  parameter int unsigned V_BLANK_LINES = 20,
  parameter int unsigned VS_LEAD       = 1,
  parameter int unsigned CLKEN_DIV     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  input  logic [7:0] const_val,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_Y,
  output logic       frame_done
);

  localparam int unsigned ACT_CLKS  = IMG_HDISP * CLKEN_DIV;
  localparam int unsigned LINE_CLKS = ACT_CLKS + H_BLANK;
  localparam int unsigned CW        = $clog2(LINE_CLKS);
  localparam int unsigned LW        = 10;
  localparam int unsigned XW        = 10;
  localparam int unsigned DW        = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VBLANK,
    S_LEAD,
    S_ACTIVE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   clk_cnt;
  logic [LW-1:0]   line_cnt;
  logic [DW-1:0]   div_cnt;
  logic [XW-1:0]   x_cnt;
  logic [1:0]      pat_q;
  logic [7:0]      cval_q;

  state_t          nxt_state;
  logic [CW-1:0]   nxt_clk;
  logic [LW-1:0]   nxt_line;
  logic [DW-1:0]   nxt_div;
  logic [XW-1:0]   nxt_x;
  logic            nxt_vsync;
  logic            nxt_href;
  logic            nxt_clken;
  logic [7:0]      nxt_y;
  logic            nxt_done;
  logic            last_clk;
  logic            last_line;
  logic            vs_rise;
  logic [1:0]      pat_use;
  logic [7:0]      cval_use;

  // Test pattern value for one pixel coordinate
  function automatic logic [7:0] pixel(input logic [1:0] pat, input logic [7:0] cval,
                                       input logic [7:0] x, input logic [7:0] y);
    logic [7:0] v;
    case (pat)
      2'd0:    v = x;
      2'd1:    v = y;
      2'd2:    v = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      default: v = cval;
    endcase
    return v;
  endfunction

  // Next raster position and the output values that position implies
  always_comb begin
    nxt_state = state_q;
    nxt_clk   = clk_cnt;
    nxt_line  = line_cnt;
    nxt_done  = 1'b0;
    last_clk  = (clk_cnt == CW'(LINE_CLKS - 1));
    case (state_q)
      S_VBLANK: last_line = (line_cnt == LW'(V_BLANK_LINES - 1));
      S_LEAD:   last_line = (line_cnt == LW'((VS_LEAD > 0) ? VS_LEAD - 1 : 0));
      S_ACTIVE: last_line = (line_cnt == LW'(IMG_VDISP - 1));
      default:  last_line = 1'b0;
    endcase

    if (state_q == S_IDLE) begin
      if (enable) begin
        nxt_state = S_VBLANK;
        nxt_clk   = '0;
        nxt_line  = '0;
      end
    end else begin
      nxt_clk = last_clk ? '0 : clk_cnt + CW'(1);
      if (last_clk) begin
        nxt_line = last_line ? '0 : line_cnt + LW'(1);
        if (last_line) begin
          case (state_q)
            S_VBLANK: nxt_state = (VS_LEAD > 0) ? S_LEAD : S_ACTIVE;
            S_LEAD:   nxt_state = S_ACTIVE;
            default: begin
              nxt_done  = 1'b1;
              nxt_state = enable ? S_VBLANK : S_IDLE;
            end
          endcase
        end
      end
    end

    nxt_vsync = (nxt_state == S_LEAD) || (nxt_state == S_ACTIVE);
    nxt_href  = (nxt_state == S_ACTIVE) && (nxt_clk < CW'(ACT_CLKS));
    nxt_div   = ((nxt_clk == '0) || (div_cnt == DW'(CLKEN_DIV - 1))) ? '0 : div_cnt + DW'(1);
    nxt_clken = nxt_href && (nxt_div == '0);
    nxt_x     = (nxt_clk == '0) ? '0 : (nxt_clken ? x_cnt + XW'(1) : x_cnt);

    // Pattern selection is frozen at the vsync rising edge
    vs_rise  = nxt_vsync && !post_frame_vsync;
    pat_use  = vs_rise ? pattern_sel : pat_q;
    cval_use = vs_rise ? const_val : cval_q;

    if (!nxt_href)
      nxt_y = 8'h00;
    else if (nxt_clken)
      nxt_y = pixel(pat_use, cval_use, nxt_x[7:0], nxt_line[7:0]);
    else
      nxt_y = post_img_Y;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      clk_cnt          <= '0;
      line_cnt         <= '0;
      div_cnt          <= '0;
      x_cnt            <= '0;
      pat_q            <= 2'd0;
      cval_q           <= 8'h00;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Y       <= 8'h00;
      frame_done       <= 1'b0;
    end else begin
      state_q          <= nxt_state;
      clk_cnt          <= nxt_clk;
      line_cnt         <= nxt_line;
      div_cnt          <= nxt_div;
      x_cnt            <= nxt_x;
      pat_q            <= pat_use;
      cval_q           <= cval_use;
      post_frame_vsync <= nxt_vsync;
      post_frame_href  <= nxt_href;
      post_frame_clken <= nxt_clken;
      post_img_Y       <= nxt_y;
      frame_done       <= nxt_done;
    end
  end

endmodule

// File: tb/tb_vip_frame_stream_gen.sv
// Bench for vip_frame_stream_gen: two instances (small ramp config and a
// 16x16 checkerboard config) compared every cycle against a frame-time model.
module tb_vip_frame_stream_gen;

  localparam int A_H = 4,  A_V = 3,  A_HB = 2, A_VB = 2, A_VL = 1, A_D = 2;
  localparam int B_H = 16, B_V = 16, B_HB = 2, B_VB = 2, B_VL = 0, B_D = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en   [2];
  logic [1:0] psel [2];
  logic [7:0] cval [2];
  logic       d_vs [2];
  logic       d_hr [2];
  logic       d_ck [2];
  logic       d_dn [2];
  logic [7:0] d_y  [2];

  bit         m_run [2];
  int         m_t   [2];
  logic [1:0] m_pat [2];
  logic [7:0] m_cv  [2];
  bit         e_vs  [2];
  bit         e_hr  [2];
  bit         e_ck  [2];
  bit         e_dn  [2];
  logic [7:0] e_y   [2];

  bit         h_vs [2][400];
  bit         h_hr [2][400];
  bit         h_ck [2][400];
  bit         h_dn [2][400];
  logic [7:0] h_y  [2][400];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vip_frame_stream_gen #(
    .IMG_HDISP(A_H), .IMG_VDISP(A_V), .H_BLANK(A_HB),
    .V_BLANK_LINES(A_VB), .VS_LEAD(A_VL), .CLKEN_DIV(A_D)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .pattern_sel(psel[0]), .const_val(cval[0]),
    .post_frame_vsync(d_vs[0]), .post_frame_href(d_hr[0]), .post_frame_clken(d_ck[0]),
    .post_img_Y(d_y[0]), .frame_done(d_dn[0])
  );

  vip_frame_stream_gen #(
    .IMG_HDISP(B_H), .IMG_VDISP(B_V), .H_BLANK(B_HB),
    .V_BLANK_LINES(B_VB), .VS_LEAD(B_VL), .CLKEN_DIV(B_D)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .pattern_sel(psel[1]), .const_val(cval[1]),
    .post_frame_vsync(d_vs[1]), .post_frame_href(d_hr[1]), .post_frame_clken(d_ck[1]),
    .post_img_Y(d_y[1]), .frame_done(d_dn[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input logic [1:0] p, input logic [7:0] c, input int x, input int y);
    case (p)
      2'd0:    return 8'(x % 256);
      2'd1:    return 8'(y % 256);
      2'd2:    return (((x / 8) + (y / 8)) % 2 == 1) ? 8'hFF : 8'h00;
      default: return c;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 1'b0; m_t[i] = 0; m_pat[i] = 2'd0; m_cv[i] = 8'h00;
      e_vs[i] = 1'b0; e_hr[i] = 1'b0; e_ck[i] = 1'b0; e_dn[i] = 1'b0; e_y[i] = 8'h00;
    end
  endtask

  // One clock of the frame-time model: position = clocks since VBLANK began
  task automatic model_tick();
    int h, v, hb, vb, vl, d, lc, fc, a, c;
    bit vs_prev;
    for (int i = 0; i < 2; i++) begin
      h  = (i == 0) ? A_H  : B_H;   v  = (i == 0) ? A_V  : B_V;
      hb = (i == 0) ? A_HB : B_HB;  vb = (i == 0) ? A_VB : B_VB;
      vl = (i == 0) ? A_VL : B_VL;  d  = (i == 0) ? A_D  : B_D;
      lc = h * d + hb;
      fc = (vb + vl + v) * lc;
      vs_prev = e_vs[i];
      e_dn[i] = 1'b0;
      if (!m_run[i]) begin
        if (en[i]) begin m_run[i] = 1'b1; m_t[i] = 0; end
      end else if (m_t[i] == fc - 1) begin
        e_dn[i]  = 1'b1;
        m_t[i]   = 0;
        m_run[i] = en[i];
      end else begin
        m_t[i]++;
      end
      e_vs[i] = m_run[i] && (m_t[i] >= vb * lc);
      if (e_vs[i] && !vs_prev) begin m_pat[i] = psel[i]; m_cv[i] = cval[i]; end
      a = m_t[i] - (vb + vl) * lc;
      if (m_run[i] && a >= 0) begin
        c = a % lc;
        e_hr[i] = (c < h * d);
        e_ck[i] = e_hr[i] && (c % d == 0);
        e_y[i]  = e_hr[i] ? pix(m_pat[i], m_cv[i], c / d, a / lc) : 8'h00;
      end else begin
        e_hr[i] = 1'b0; e_ck[i] = 1'b0; e_y[i] = 8'h00;
      end
    end
  endtask

  // Advance one clock, update the model, then compare both DUTs on the falling edge
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("cmp_vsync_%0d", i), d_vs[i], e_vs[i]);
      chk($sformatf("cmp_href_%0d", i),  d_hr[i], e_hr[i]);
      chk($sformatf("cmp_clken_%0d", i), d_ck[i], e_ck[i]);
      chk($sformatf("cmp_y_%0d", i),     d_y[i],  e_y[i]);
      chk($sformatf("cmp_done_%0d", i),  d_dn[i], e_dn[i]);
    end
  endtask

  task automatic record(input int k);
    for (int i = 0; i < 2; i++) begin
      h_vs[i][k] = d_vs[i]; h_hr[i][k] = d_hr[i]; h_ck[i][k] = d_ck[i];
      h_dn[i][k] = d_dn[i]; h_y[i][k]  = d_y[i];
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    en[0] = 1'b0;   en[1] = 1'b0;
    psel[0] = 2'd0; psel[1] = 2'd2;
    cval[0] = 8'h00; cval[1] = 8'h00;
    model_reset();
    repeat (3) step();
    chk("reset_vsync", d_vs[0], 0);
    chk("reset_href",  d_hr[0], 0);
    chk("reset_y",     d_y[0],  0);
    chk("reset_done",  d_dn[0], 0);

    // Clock 0: reset released and enable raised together
    rst_n = 1'b1; en[0] = 1'b1; en[1] = 1'b1;
    for (int k = 1; k <= 353; k++) begin
      step();
      record(k);
      if (k == 40)  psel[0] = 2'd1;
      if (k == 95)  begin psel[0] = 2'd3; cval[0] = 8'hA5; end
      if (k == 155) en[0] = 1'b0;
      if (k == 200) en[0] = 1'b1;
    end

    // Frame timing, first frame and back-to-back second frame
    chk("t1_vs_20", h_vs[0][20], 0);
    chk("t1_vs_21", h_vs[0][21], 1);
    chk("t1_hr_30", h_hr[0][30], 0);
    chk("t1_hr_31", h_hr[0][31], 1);
    chk("t1_done_60", h_dn[0][60], 0);
    chk("t1_done_61", h_dn[0][61], 1);
    chk("t1_done_62", h_dn[0][62], 0);
    chk("t1_vs_61", h_vs[0][61], 0);
    chk("t1_vs_80", h_vs[0][80], 0);
    chk("t1_vs_81", h_vs[0][81], 1);
    chk("t1_hr_38", h_hr[0][38], 1);
    chk("t1_hr_39", h_hr[0][39], 0);
    chk("t1_hr_40", h_hr[0][40], 0);
    chk("t1_hr_41", h_hr[0][41], 1);

    // Horizontal ramp: 4 pulses per line with Y=0..3, 12 per frame
    n = 0;
    for (int k = 31; k <= 40; k++)
      if (h_ck[0][k]) begin
        chk("t2_ramp_y", h_y[0][k], n);
        n++;
      end
    chk("t2_line_clkens", n, 4);
    n = 0;
    for (int k = 31; k <= 60; k++) if (h_ck[0][k]) n++;
    chk("t2_frame_clkens", n, 12);
    chk("t2_y_hold", h_y[0][34], 1);
    chk("t2_y_blank", h_y[0][39], 0);
    chk("t2_midframe_sel", h_y[0][47], 3);

    // Vertical ramp in frame 2; const pattern only from frame 3
    chk("t3_line0", h_y[0][92], 0);
    chk("t3_line1", h_y[0][103], 1);
    chk("t3_line2", h_y[0][115], 2);
    chk("t3_const", h_y[0][151], 8'hA5);
    chk("t3_const_b", h_y[0][157], 8'hA5);

    // Checkerboard on 16x16, VS_LEAD=0, DIV=1
    chk("t4_vs_36", h_vs[1][36], 0);
    chk("t4_vs_37", h_vs[1][37], 1);
    chk("t4_hr_37", h_hr[1][37], 1);
    chk("t4_ck_37", h_ck[1][37], 1);
    chk("t4_r0_x0", h_y[1][37], 8'h00);
    chk("t4_r0_x7", h_y[1][44], 8'h00);
    chk("t4_r0_x8", h_y[1][45], 8'hFF);
    chk("t4_r0_x15", h_y[1][52], 8'hFF);
    chk("t4_r0_blank", h_y[1][53], 8'h00);
    chk("t4_r7_x0", h_y[1][163], 8'h00);
    chk("t4_r8_x0", h_y[1][181], 8'hFF);
    chk("t4_r8_x8", h_y[1][189], 8'h00);
    chk("t4_r15_x0", h_y[1][307], 8'hFF);
    chk("t4_r15_x15", h_y[1][322], 8'h00);
    chk("t4_done", h_dn[1][325], 1);
    n = 0;
    for (int k = 37; k <= 54; k++) if (h_ck[1][k]) n++;
    chk("t4_line_clkens", n, 16);

    // Enable dropped mid-line: frame completes, one done pulse, then idle
    chk("t5_last_line", h_hr[0][171], 1);
    chk("t5_done", h_dn[0][181], 1);
    n = 0;
    for (int k = 161; k <= 200; k++) if (h_dn[0][k]) n++;
    chk("t5_done_count", n, 1);
    n = 0;
    for (int k = 182; k <= 201; k++)
      if (h_vs[0][k] || h_hr[0][k] || h_ck[0][k] || h_dn[0][k] || h_y[0][k] != 8'h00) n++;
    chk("t5_idle_quiet", n, 0);
    chk("t5_re_vs_220", h_vs[0][220], 0);
    chk("t5_re_vs_221", h_vs[0][221], 1);
    chk("t5_re_hr_231", h_hr[0][231], 1);

    // Asynchronous reset in the middle of href
    chk("t6_in_href", h_hr[0][353], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_vs", d_vs[0], 0);
    chk("t6_async_hr", d_hr[0], 0);
    chk("t6_async_ck", d_ck[0], 0);
    chk("t6_async_y",  d_y[0],  0);
    chk("t6_async_done", d_dn[0], 0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 62; k++) begin
      step();
      record(k);
    end
    chk("t6_vs_20", h_vs[0][20], 0);
    chk("t6_vs_21", h_vs[0][21], 1);
    chk("t6_hr_30", h_hr[0][30], 0);
    chk("t6_hr_31", h_hr[0][31], 1);
    chk("t6_done_61", h_dn[0][61], 1);
    chk("t6_b_vs_37", h_vs[1][37], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
